// File: rtl/led_req_if.sv
// LED arbiter bus: requester inputs and LED-side outputs bundled together.
// The arbiter connects through the slave modport; the bench or board glue drives the master side.
interface led_req_if;
  logic [3:0]  req;
  logic [15:0] pat;
  logic [3:0]  grant;
  logic [3:0]  led;
  logic        tick;

  modport master (output req, output pat, input grant, input led, input tick);
  modport slave  (input req, input pat, output grant, output led, output tick);
endinterface

// File: rtl/led_req_arbiter.sv
// Round-robin owner of the 4-LED bank. Each of four requesters offers a 4-bit pattern.
// A grant is shown for at least HOLD_TICKS step ticks. When nobody requests, a
// walking-one chaser runs. The prescaler is the single step timebase for the block.
// Optional build macro LED_REQ_BLINK_EN: the granted pattern blinks, toggling on every tick.
module led_req_arbiter #(
  parameter int CLK_DIV    = 50_000_000,
  parameter int HOLD_TICKS = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  led_req_if.slave bus
);

  localparam int              HW       = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(HOLD_TICKS);
  localparam logic [31:0]     DIV_LAST = 32'(CLK_DIV - 1);
  localparam logic [31:0]     DIV_PRE  = 32'(CLK_DIV - 2);

  typedef enum logic {S_IDLE, S_SHOW} state_t;

  // First set request bit at or after (last+1), wrapping around the four requesters.
  function automatic logic [1:0] f_arb(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    f_arb = 2'(last + 2'd1);
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = 2'(last + 2'(k));
      if (!found && req[idx]) begin
        f_arb = idx;
        found = 1'b1;
      end
    end
  endfunction

  logic [31:0]   r_cnt;
  logic          r_tick;
  state_t        r_state,  w_state_nxt;
  logic [3:0]    r_chaser, w_chaser_nxt;
  logic [HW-1:0] r_hold,   w_hold_nxt;
  logic [1:0]    r_last,   w_last_nxt;
  logic [3:0]    r_grant,  w_grant_nxt;
  logic [3:0]    r_led,    w_led_nxt;
`ifdef LED_REQ_BLINK_EN
  logic          r_phase,  w_phase_nxt;
  logic [3:0]    r_pat,    w_pat_nxt;
`endif

  logic [3:0]    w_req;
  logic [15:0]   w_pat;
  logic [1:0]    w_win;
  logic [3:0]    w_win_pat;
  logic [3:0]    w_others;
  logic          w_do_grant;
  logic          w_go_idle;

  assign w_req     = bus.req;
  assign w_pat     = bus.pat;
  assign w_win     = f_arb(w_req, r_last);
  assign w_win_pat = w_pat[{w_win, 2'b00} +: 4];
  assign w_others  = w_req & ~r_grant;

  assign bus.grant = r_grant;
  assign bus.led   = r_led;
  assign bus.tick  = r_tick;

  // Free-running prescaler; tick is registered so it is high exactly while the count sits at CLK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == DIV_PRE);
      r_cnt  <= (r_cnt == DIV_LAST) ? '0 : r_cnt + 32'd1;
    end
  end

  // State register and all registered outputs of the arbiter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_chaser <= 4'b0001;
      r_hold   <= '0;
      r_last   <= 2'd3;
      r_grant  <= 4'b0000;
      r_led    <= 4'b0000;
`ifdef LED_REQ_BLINK_EN
      r_phase  <= 1'b1;
      r_pat    <= 4'b0000;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_chaser <= w_chaser_nxt;
      r_hold   <= w_hold_nxt;
      r_last   <= w_last_nxt;
      r_grant  <= w_grant_nxt;
      r_led    <= w_led_nxt;
`ifdef LED_REQ_BLINK_EN
      r_phase  <= w_phase_nxt;
      r_pat    <= w_pat_nxt;
`endif
    end
  end

  // Next state: chaser stepping in IDLE, hold counting in SHOW, grant/hand-over/release decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_chaser_nxt = r_chaser;
    w_hold_nxt   = r_hold;
    w_last_nxt   = r_last;
    w_grant_nxt  = r_grant;
    w_led_nxt    = r_led;
`ifdef LED_REQ_BLINK_EN
    w_phase_nxt  = r_phase;
    w_pat_nxt    = r_pat;
`endif
    w_do_grant   = 1'b0;
    w_go_idle    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_tick) begin
          w_chaser_nxt = {r_chaser[2:0], r_chaser[3]};
        end
        if (w_req != 4'b0000) begin
          w_do_grant = 1'b1;
        end else begin
          w_grant_nxt = 4'b0000;
          w_led_nxt   = w_chaser_nxt;
        end
      end
      S_SHOW: begin
        if (r_tick) begin
          if (r_hold != HOLD_MAX) begin
            w_hold_nxt = r_hold + 1'b1;
          end
`ifdef LED_REQ_BLINK_EN
          w_phase_nxt = ~r_phase;
`endif
        end
        // The registered count decides exit, so a tick that completes the hold acts one cycle later.
        if (r_hold == HOLD_MAX) begin
          if (w_others != 4'b0000) begin
            w_do_grant = 1'b1;
          end else if (w_req == 4'b0000) begin
            w_go_idle = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_do_grant) begin
      w_state_nxt = S_SHOW;
      w_grant_nxt = 4'b0001 << w_win;
      w_last_nxt  = w_win;
      w_led_nxt   = w_win_pat;
      w_hold_nxt  = '0;
`ifdef LED_REQ_BLINK_EN
      w_phase_nxt = 1'b1;
      w_pat_nxt   = w_win_pat;
`endif
    end else if (w_go_idle) begin
      // Chaser was frozen during SHOW, so it resumes exactly where it left off.
      w_state_nxt = S_IDLE;
      w_grant_nxt = 4'b0000;
      w_led_nxt   = r_chaser;
    end else if (r_state == S_SHOW) begin
`ifdef LED_REQ_BLINK_EN
      w_led_nxt = w_phase_nxt ? r_pat : 4'b0000;
`else
      w_led_nxt = r_led;
`endif
    end
  end

endmodule

// File: doc/led_req_arbiter.md
Name: led_req_arbiter

Overview:
- Shares the 4-LED bank between four status requesters, each supplying its own 4-bit pattern.
- Round-robin arbitration with a guaranteed minimum display time per grant.
- When no requester is active, drives a 4-step walking-one chaser.
- Sits between the board LED pins and the status sources; its prescaler provides the single timebase.

Parameters:
- CLK_DIV, 50_000_000: clk cycles per step tick (>=2).
- HOLD_TICKS, 4: minimum step ticks a granted pattern stays displayed (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  4  per-requester display request, level-sensitive
- pat  in  16  requester patterns; pat[4i+3:4i] belongs to requester i
- grant  out  4  one-hot current owner; 0 when idle
- led  out  4  LED drive, registered
- tick  out  1  one-cycle step pulse, registered

Behaviour:
- Reset: clk and rst_n are the block clock and reset; rst_n is asynchronous, active-low.
- Reset values:
  - led=4'b0000, grant=4'b0000, tick=0.
  - Prescaler = 0; chaser = 4'b0001; hold_cnt = 0.
  - Round-robin pointer last = 3, so requester 0 has first priority.
  - State = IDLE.
- Prescaler:
  - 32-bit counter runs 0..CLK_DIV-1 and wraps to 0.
  - tick=1 for the one cycle in which the counter equals CLK_DIV-1, so period = CLK_DIV cycles.
  - Runs in all states.
- Arbitration function:
  - Scan req from index (last+1) mod 4 upward, wrapping.
  - The first set bit wins.
  - Used on IDLE exit and on SHOW hand-over.
- State IDLE:
  - grant=0; led=chaser, registered.
  - On tick, chaser rotates left: 0001->0010->0100->1000->0001.
  - If req!=0: at the next edge go to SHOW with winner w.
    - grant=onehot(w); last=w; latch led=pat[w] and hold_cnt=0.
    - Latency from req asserted to led/grant change: 1 clk.
- State SHOW:
  - led holds the latched pattern; later pat changes are ignored until the next grant.
  - On tick, hold_cnt increments, saturating at HOLD_TICKS.
  - Exit is evaluated only when hold_cnt==HOLD_TICKS:
    - req[w]=1 and no other req bit set: stay, no re-latch.
    - Any other req bit set: re-arbitrate from last+1 at the next edge. This may return w only if w is the sole requester. New grant, new latch, hold_cnt=0. No idle gap.
    - req==0: go to IDLE next edge. Chaser resumes from its retained value; it is not advanced during SHOW.
  - If req[w] drops before hold is met: keep displaying until hold_cnt==HOLD_TICKS, then apply the rules above.
- Simultaneous events: a tick in the same cycle that hold_cnt reaches HOLD_TICKS counts. Exit is evaluated on the following cycle using the registered hold_cnt.
- Arithmetic: hold_cnt is clog2(HOLD_TICKS+1) bits, saturating; the pointer wraps mod 4.
- Reset mid-SHOW: all outputs return immediately (asynchronously) to reset values; any grant is lost.

Optional Feature:
- Macro: LED_REQ_BLINK_EN.
- Defined:
  - In SHOW, a blink phase register (reset 1) toggles on every tick.
  - led = latched pattern when phase=1, 4'b0000 when phase=0.
  - Phase is forced to 1 on every new grant.
  - IDLE behaviour is unchanged.
- Undefined: no phase register; SHOW pattern is steady.

Test Plan (CLK_DIV=4, HOLD_TICKS=2):
- Reset release, req=0 -> led=0000 during reset, 0001 first edge after release; tick every 4 clk; led steps to 0010, 0100, 1000, 0001 on successive ticks; grant=0 throughout.
- req=0001, pat[3:0]=1010 -> one clk later grant=0001, led=1010. Drop req after 1 clk -> led stays 1010 until 2 ticks have elapsed, then returns to the chaser value held at grant time.
- req=0101 held, pat0=0011, pat2=1100 -> grant 0001 (led 0011) for 2 ticks, then 0100 (led 1100) for 2 ticks, then 0001 again; no cycle with grant=0.
- Grant req1 with pat1=0110, change pat1 to 1111 mid-hold -> led stays 0110.
- Assert rst_n=0 mid-SHOW (asynchronously) -> grant=0 and led=0000 immediately; after release, arbitration restarts from requester 0.
- With LED_REQ_BLINK_EN, req=1000, pat3=1001 -> led=1001 for the first tick period, 0000 the next, alternating while the grant is held.
